amo_ctrl: RTL and testbench
===========================

AMO_CTRL -- requirements
Module: amo_ctrl

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data/address width; N_IDS, default 1, number of reservation-table IDs; HART_ID, default 0, ID driven on o_res_id.
REQ-002 Ports SHALL be, one per line:
  i_clk  in  1  clock; all state on rising edge.
  i_rst  in  1  reset, asynchronous, active-high.
  i_start  in  1  core request strobe.
  i_funct5  in  5  RISC-V A-extension funct5.
  i_addr  in  XLEN  operand rs1, the target address.
  i_rs2  in  XLEN  operand rs2.
  o_busy  out  1  high whenever state is not IDLE.
  o_done  out  1  one-cycle completion pulse.
  o_rd  out  XLEN  result; valid while o_done is high.
  o_illegal  out  1  one-cycle pulse for an unsupported funct5.
  o_misaligned  out  1  one-cycle pulse when i_addr[1:0] is not 0.
  o_mem_req  out  1  memory request.
  o_mem_we  out  1  write when 1, read when 0.
  o_mem_addr  out  XLEN  word address.
  o_mem_wdata  out  XLEN  write data.
  i_mem_ack  in  1  request accepted or completed; i_mem_rdata is valid in the same cycle.
  i_mem_rdata  in  XLEN  read data.
  o_res_set  out  1  to the reservation table: set a reservation.
  o_res_check  out  1  to the reservation table: check a reservation.
  o_res_wr  out  1  to the reservation table: a store was performed.
  o_res_id  out  clog2(N_IDS)  fixed at HART_ID.
  o_res_addr  out  XLEN  reservation address.
  i_res_gnt  in  1  combinational grant, valid in the same cycle as o_res_check.

Function
REQ-003 The supported funct5 encodings SHALL be: LR 00010, SC 00011, SWAP 00001, ADD 00000, XOR 00100, AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
REQ-004 The state machine SHALL have the states IDLE, READ, CHECK, WRITE, DONE.
REQ-005 i_start SHALL be sampled only in IDLE, and operands SHALL be latched at that edge; i_start SHALL be ignored while o_busy is high.
REQ-006 In IDLE with i_start high, an illegal funct5 or a misaligned address SHALL go to DONE and pulse the matching error flag with o_done, with o_rd = 0; no memory or reservation access SHALL occur.
   - If both conditions hold, o_illegal SHALL take priority and o_misaligned SHALL stay low.
REQ-007 IDLE SHALL go to CHECK for SC, and to READ for LR and all AMO operations.
REQ-008 In READ, o_mem_req SHALL be 1 with o_mem_we = 0; on i_mem_ack the read data SHALL be latched.
   - LR: pulse o_res_set in the ack cycle (o_res_addr = latched address), then go to DONE with o_rd = rdata.
   - AMO: go to WRITE with o_rd = rdata (the old value).
REQ-009 CHECK SHALL last exactly one cycle with o_res_check = 1.
   - i_res_gnt = 1: go to WRITE with wdata = rs2.
   - i_res_gnt = 0: go to DONE with o_rd = 1; no memory write SHALL occur.
REQ-010 In WRITE, o_mem_req SHALL be 1 with o_mem_we = 1; on i_mem_ack, o_res_wr SHALL pulse and the block SHALL go to DONE.
   - SC: o_rd = 0.
   - AMO: o_rd = the old value.
REQ-011 AMO write data SHALL be computed from the old value (a) and rs2 (b) as XLEN-bit results with wrap-around.
   - ADD: a+b, carry discarded.
   - SWAP: b.
   - XOR, AND, OR: bitwise.
   - MIN, MAX: signed compare; MINU, MAXU: unsigned compare.
   - On equality, MIN and MAX SHALL select a.
REQ-012 o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata SHALL be registered and held stable from assertion until the i_mem_ack cycle inclusive; o_mem_req SHALL drop the cycle after ack.
   - The wait for i_mem_ack SHALL be unbounded.
REQ-013 DONE SHALL last one cycle with o_done = 1, then go to IDLE; a new i_start SHALL be accepted at the earliest in the cycle after DONE.
REQ-014 Minimum latency, i_start cycle to o_done cycle, with zero-wait ack:
   - LR: 2.
   - SC fail: 2.
   - SC success: 3.
   - AMO: 3.
   - Illegal or misaligned: 1.
REQ-015 o_res_set, o_res_check and o_res_wr SHALL be mutually exclusive single-cycle pulses; o_res_addr SHALL equal the latched address whenever any of them is high.

Reset
REQ-016 Reset SHALL be asynchronous and active-high: on i_res high the state SHALL be IDLE immediately.
   - o_busy, o_done, o_rd, o_illegal, o_misaligned, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_res_set, o_res_check and o_res_wr SHALL all be 0.
REQ-017 A reset asserted during READ or WRITE SHALL abandon the operation, drop o_mem_req immediately, and never produce o_done or o_res_wr for the abandoned operation.

Verification
REQ-018 LR then SC: LR to 0x100 with rdata 0xDEADBEEF -> o_rd = 0xDEADBEEF and an o_res_set pulse; SC to 0x100 with rs2 = 5 and gnt = 1 -> a write of 5 to 0x100, o_res_wr pulse, o_rd = 0.
REQ-019 SC fail: gnt = 0 -> o_mem_req never asserted, o_rd = 1, o_done two cycles after i_start.
REQ-020 AMO arithmetic:
   - ADD with old 0xFFFFFFFF and rs2 = 2 -> write 0x00000001, o_rd = 0xFFFFFFFF.
   - MIN with old 0x80000000 and rs2 = 1 -> write 0x80000000.
   - MINU with the same operands -> write 0x00000001.
REQ-021 Errors: funct5 = 11111 -> o_illegal and o_done in one cycle, no o_mem_req; address 0x102 -> o_misaligned and o_done, no o_mem_req.
REQ-022 Backpressure and reset: hold i_mem_ack low for 10 cycles during an AMO write -> request fields stable throughout; a second run with reset asserted mid-wait -> o_mem_req 0 immediately, no o_done, and the next i_start is accepted normally.

Source files
------------

// File: rtl/amo_ctrl.sv
// RISC-V A-extension controller: sequences LR, SC and AMO read-modify-write
// operations against a single-port memory and a reservation table.
module amo_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned N_IDS   = 1,
    parameter int unsigned HART_ID = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [4:0]           i_funct5,
    input  logic [XLEN-1:0]      i_addr,
    input  logic [XLEN-1:0]      i_rs2,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [XLEN-1:0]      o_rd,
    output logic                 o_illegal,
    output logic                 o_misaligned,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [XLEN-1:0]      o_mem_addr,
    output logic [XLEN-1:0]      o_mem_wdata,
    input  logic                 i_mem_ack,
    input  logic [XLEN-1:0]      i_mem_rdata,
    output logic                 o_res_set,
    output logic                 o_res_check,
    output logic                 o_res_wr,
    output logic [(N_IDS > 1 ? $clog2(N_IDS) : 1)-1:0] o_res_id,
    output logic [XLEN-1:0]      o_res_addr,
    input  logic                 i_res_gnt
);

    localparam int unsigned ID_W = (N_IDS > 1) ? $clog2(N_IDS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    function automatic logic f_legal(input logic [4:0] f);
        logic v;
        case (f)
            F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR,
            F_MIN, F_MAX, F_MINU, F_MAXU: v = 1'b1;
            default:                      v = 1'b0;
        endcase
        return v;
    endfunction

    // New memory value from old value a and operand b; ties keep a.
    function automatic logic [XLEN-1:0] f_alu(input logic [4:0] f,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (f)
            F_ADD:   r = a + b;
            F_XOR:   r = a ^ b;
            F_AND:   r = a & b;
            F_OR:    r = a | b;
            F_MIN:   r = ($signed(b) < $signed(a)) ? b : a;
            F_MAX:   r = ($signed(b) > $signed(a)) ? b : a;
            F_MINU:  r = (b < a) ? b : a;
            F_MAXU:  r = (b > a) ? b : a;
            default: r = b;
        endcase
        return r;
    endfunction

    logic [2:0]      r_state, w_state;
    logic [4:0]      r_f5, w_f5;
    logic [XLEN-1:0] r_addr, w_addr;
    logic [XLEN-1:0] r_rs2, w_rs2;
    logic [XLEN-1:0] r_old, w_old;
    logic [XLEN-1:0] r_rd, w_rd;
    logic            r_ill, w_ill;
    logic            r_mis, w_mis;
    logic            r_mem_req, w_mem_req;
    logic            r_mem_we, w_mem_we;
    logic [XLEN-1:0] r_mem_addr, w_mem_addr;
    logic [XLEN-1:0] r_mem_wdata, w_mem_wdata;
    logic            r_busy, r_done;
    logic            w_res_set, w_res_wr;

    // Next-state and next-output logic
    always_comb begin
        w_state     = r_state;
        w_f5        = r_f5;
        w_addr      = r_addr;
        w_rs2       = r_rs2;
        w_old       = r_old;
        w_rd        = r_rd;
        w_ill       = 1'b0;
        w_mis       = 1'b0;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_res_set   = 1'b0;
        w_res_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_f5   = i_funct5;
                    w_addr = i_addr;
                    w_rs2  = i_rs2;
                    if (!f_legal(i_funct5)) begin
                        w_state = S_DONE;
                        w_ill   = 1'b1;
                        w_rd    = '0;
                    end else if (i_addr[1:0] != 2'b00) begin
                        w_state = S_DONE;
                        w_mis   = 1'b1;
                        w_rd    = '0;
                    end else if (i_funct5 == F_SC) begin
                        w_state = S_CHECK;
                    end else begin
                        w_state    = S_READ;
                        w_mem_req  = 1'b1;
                        w_mem_we   = 1'b0;
                        w_mem_addr = i_addr;
                    end
                end
            end
            S_READ: begin
                if (i_mem_ack) begin
                    w_old = i_mem_rdata;
                    if (r_f5 == F_LR) begin
                        w_res_set = 1'b1;
                        w_state   = S_DONE;
                        w_rd      = i_mem_rdata;
                        w_mem_req = 1'b0;
                    end else begin
                        w_state     = S_WRITE;
                        w_mem_req   = 1'b1;
                        w_mem_we    = 1'b1;
                        w_mem_wdata = f_alu(r_f5, i_mem_rdata, r_rs2);
                    end
                end
            end
            S_CHECK: begin
                if (i_res_gnt) begin
                    w_state     = S_WRITE;
                    w_mem_req   = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_addr;
                    w_mem_wdata = r_rs2;
                end else begin
                    w_state = S_DONE;
                    w_rd    = XLEN'(1);
                end
            end
            S_WRITE: begin
                if (i_mem_ack) begin
                    w_res_wr  = 1'b1;
                    w_state   = S_DONE;
                    w_mem_req = 1'b0;
                    w_mem_we  = 1'b0;
                    w_rd      = (r_f5 == F_SC) ? '0 : r_old;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_f5        <= '0;
            r_addr      <= '0;
            r_rs2       <= '0;
            r_old       <= '0;
            r_rd        <= '0;
            r_ill       <= 1'b0;
            r_mis       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_f5        <= w_f5;
            r_addr      <= w_addr;
            r_rs2       <= w_rs2;
            r_old       <= w_old;
            r_rd        <= w_rd;
            r_ill       <= w_ill;
            r_mis       <= w_mis;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_busy      <= (w_state != S_IDLE);
            r_done      <= (w_state == S_DONE);
        end
    end

    // Reservation pulses coincide with the memory ack / CHECK cycle they describe
    assign o_res_set    = w_res_set;
    assign o_res_wr     = w_res_wr;
    assign o_res_check  = (r_state == S_CHECK);
    assign o_res_id     = ID_W'(HART_ID);
    assign o_res_addr   = r_addr;

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_rd         = r_rd;
    assign o_illegal    = r_ill;
    assign o_misaligned = r_mis;
    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_amo_ctrl.sv
// Directed bench for amo_ctrl: table of single operations plus backpressure,
// reset-abandon and busy-ignore sequences, with a cycle-level memory responder.
module tb_amo_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [4:0]  i_funct5;
    logic [31:0] i_addr, i_rs2;
    logic        o_busy, o_done, o_illegal, o_misaligned;
    logic [31:0] o_rd;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_res_set, o_res_check, o_res_wr;
    logic [0:0]  o_res_id;
    logic [31:0] o_res_addr;
    logic        i_res_gnt;

    amo_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_funct5(i_funct5),
        .i_addr(i_addr), .i_rs2(i_rs2), .o_busy(o_busy), .o_done(o_done),
        .o_rd(o_rd), .o_illegal(o_illegal), .o_misaligned(o_misaligned),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_res_set(o_res_set), .o_res_check(o_res_check), .o_res_wr(o_res_wr),
        .o_res_id(o_res_id), .o_res_addr(o_res_addr), .i_res_gnt(i_res_gnt)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Observations gathered by do_op
    int          res_lat, res_nreq, res_nwr, res_nset, res_nchk, res_nwrp, res_bad, res_unstable;
    logic [31:0] res_rd, res_wdata, res_maddr;
    logic        res_ill, res_mis;

    typedef struct {
        logic [4:0]  f5;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        gnt;
        logic [31:0] exp_rd;
        int          lat;
        logic        ill;
        logic        mis;
        int          nreq;
        int          nwr;
        logic [31:0] wdata;
        int          nset;
        int          nchk;
        int          nwrp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one operation from an IDLE cycle and act as memory/reservation responder.
    task automatic do_op(input logic [4:0] f5, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input logic gnt, input int wr_wait,
                         input bit hold);
        bit          done, in_req;
        int          wcnt;
        logic        s_we;
        logic [31:0] s_addr, s_wdata;
        res_lat = 0; res_nreq = 0; res_nwr = 0; res_nset = 0; res_nchk = 0;
        res_nwrp = 0; res_bad = 0; res_unstable = 0;
        res_rd = 'x; res_wdata = 'x; res_maddr = 'x; res_ill = 1'bx; res_mis = 1'bx;
        done = 0; in_req = 0; wcnt = 0; s_we = 0; s_addr = 0; s_wdata = 0;
        i_start = 1'b1; i_funct5 = f5; i_addr = addr; i_rs2 = rs2; i_res_gnt = gnt;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(posedge i_clk); #1;
            i_mem_ack = 1'b0;
            if (hold) begin
                i_funct5 = 5'b11111;
                i_addr   = 32'h3;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                done = 1; res_lat = cyc; res_rd = o_rd;
                res_ill = o_illegal; res_mis = o_misaligned;
                i_start = 1'b0;
            end
            if (o_mem_req) begin
                res_nreq++;
                res_maddr = o_mem_addr;
                if (!in_req) begin
                    in_req = 1; wcnt = 0;
                    s_we = o_mem_we; s_addr = o_mem_addr; s_wdata = o_mem_wdata;
                end else if (s_we !== o_mem_we || s_addr !== o_mem_addr ||
                             (s_we && s_wdata !== o_mem_wdata)) begin
                    res_unstable++;
                end
                if (!o_mem_we || wcnt >= wr_wait) begin
                    i_mem_ack = 1'b1; i_mem_rdata = rdata; in_req = 0;
                    if (o_mem_we) begin
                        res_nwr++; res_wdata = o_mem_wdata;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                in_req = 0;
            end
            i_res_gnt = gnt;
            #1;
            if (o_res_set)   res_nset++;
            if (o_res_check) res_nchk++;
            if (o_res_wr)    res_nwrp++;
            if ((o_res_set || o_res_check || o_res_wr) && o_res_addr !== addr) res_bad++;
            if (int'(o_res_set) + int'(o_res_check) + int'(o_res_wr) > 1) res_bad++;
        end
        i_mem_ack = 1'b0; i_start = 1'b0;
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL op_timeout: got no o_done required o_done within 60 cycles");
        end
        @(posedge i_clk); #1;
    endtask

    initial begin
        //          f5        addr          rs2           rdata        gnt  exp_rd       lat ill mis nreq nwr wdata         set chk wrp
        vecs[0]  = '{5'b00010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2, 1'b0, 1'b0, 1, 0, 32'h0,        1, 0, 0};
        vecs[1]  = '{5'b00011, 32'h100, 32'h5,        32'h0,        1'b1, 32'h0,        3, 1'b0, 1'b0, 1, 1, 32'h5,        0, 1, 1};
        vecs[2]  = '{5'b00011, 32'h100, 32'h5,        32'h0,        1'b0, 32'h1,        2, 1'b0, 1'b0, 0, 0, 32'h0,        0, 1, 0};
        vecs[3]  = '{5'b00000, 32'h200, 32'h2,        32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 3, 1'b0, 1'b0, 2, 1, 32'h00000001, 0, 0, 1};
        vecs[4]  = '{5'b10000, 32'h204, 32'h1,        32'h80000000, 1'b0, 32'h80000000, 3, 1'b0, 1'b0, 2, 1, 32'h80000000, 0, 0, 1};
        vecs[5]  = '{5'b11000, 32'h204, 32'h1,        32'h80000000, 1'b0, 32'h80000000, 3, 1'b0, 1'b0, 2, 1, 32'h00000001, 0, 0, 1};
        vecs[6]  = '{5'b10100, 32'h208, 32'h1,        32'h80000000, 1'b0, 32'h80000000, 3, 1'b0, 1'b0, 2, 1, 32'h00000001, 0, 0, 1};
        vecs[7]  = '{5'b11100, 32'h208, 32'h1,        32'h80000000, 1'b0, 32'h80000000, 3, 1'b0, 1'b0, 2, 1, 32'h80000000, 0, 0, 1};
        vecs[8]  = '{5'b00001, 32'h20C, 32'hCAFEF00D, 32'h12345678, 1'b0, 32'h12345678, 3, 1'b0, 1'b0, 2, 1, 32'hCAFEF00D, 0, 0, 1};
        vecs[9]  = '{5'b00100, 32'h210, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 32'hF0F0F0F0, 3, 1'b0, 1'b0, 2, 1, 32'h0FF00FF0, 0, 0, 1};
        vecs[10] = '{5'b01100, 32'h210, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 32'hF0F0F0F0, 3, 1'b0, 1'b0, 2, 1, 32'hF000F000, 0, 0, 1};
        vecs[11] = '{5'b01000, 32'h210, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 32'hF0F0F0F0, 3, 1'b0, 1'b0, 2, 1, 32'hFFF0FFF0, 0, 0, 1};
        vecs[12] = '{5'b10000, 32'h214, 32'hFFFFFFFD, 32'h00000005, 1'b0, 32'h00000005, 3, 1'b0, 1'b0, 2, 1, 32'hFFFFFFFD, 0, 0, 1};
        vecs[13] = '{5'b11111, 32'h100, 32'h0,        32'h0,        1'b0, 32'h0,        1, 1'b1, 1'b0, 0, 0, 32'h0,        0, 0, 0};
        vecs[14] = '{5'b00000, 32'h102, 32'h1,        32'h0,        1'b0, 32'h0,        1, 1'b0, 1'b1, 0, 0, 32'h0,        0, 0, 0};
        vecs[15] = '{5'b00101, 32'h103, 32'h1,        32'h0,        1'b0, 32'h0,        1, 1'b1, 1'b0, 0, 0, 32'h0,        0, 0, 0};

        i_rst = 1'b1; i_start = 1'b0; i_funct5 = '0; i_addr = '0; i_rs2 = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0; i_res_gnt = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy",  32'(o_busy), 32'h0);
        chk("rst_done",  32'(o_done), 32'h0);
        chk("rst_rd",    o_rd, 32'h0);
        chk("rst_err",   32'({o_illegal, o_misaligned}), 32'h0);
        chk("rst_mem",   32'({o_mem_req, o_mem_we}), 32'h0);
        chk("rst_maddr", o_mem_addr, 32'h0);
        chk("rst_wdata", o_mem_wdata, 32'h0);
        chk("rst_res",   32'({o_res_set, o_res_check, o_res_wr}), 32'h0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        for (int v = 0; v < 16; v++) begin
            do_op(vecs[v].f5, vecs[v].addr, vecs[v].rs2, vecs[v].rdata, vecs[v].gnt, 0, 1'b0);
            chk($sformatf("v%0d_lat", v),  32'(res_lat), 32'(vecs[v].lat));
            chk($sformatf("v%0d_rd", v),   res_rd, vecs[v].exp_rd);
            chk($sformatf("v%0d_ill", v),  32'(res_ill), 32'(vecs[v].ill));
            chk($sformatf("v%0d_mis", v),  32'(res_mis), 32'(vecs[v].mis));
            chk($sformatf("v%0d_nreq", v), 32'(res_nreq), 32'(vecs[v].nreq));
            chk($sformatf("v%0d_nwr", v),  32'(res_nwr), 32'(vecs[v].nwr));
            if (vecs[v].nwr > 0)  chk($sformatf("v%0d_wdata", v), res_wdata, vecs[v].wdata);
            if (vecs[v].nreq > 0) chk($sformatf("v%0d_maddr", v), res_maddr, vecs[v].addr);
            chk($sformatf("v%0d_nset", v), 32'(res_nset), 32'(vecs[v].nset));
            chk($sformatf("v%0d_nchk", v), 32'(res_nchk), 32'(vecs[v].nchk));
            chk($sformatf("v%0d_nwrp", v), 32'(res_nwrp), 32'(vecs[v].nwrp));
            chk($sformatf("v%0d_resaddr", v), 32'(res_bad), 32'h0);
        end

        // Write held off for 10 cycles: request fields must not move
        do_op(5'b00000, 32'h300, 32'h10, 32'h20, 1'b0, 10, 1'b0);
        chk("bp_lat",      32'(res_lat), 32'd13);
        chk("bp_nreq",     32'(res_nreq), 32'd12);
        chk("bp_unstable", 32'(res_unstable), 32'h0);
        chk("bp_wdata",    res_wdata, 32'h30);
        chk("bp_rd",       res_rd, 32'h20);

        // i_start held high through a busy LR with changed operands
        do_op(5'b00010, 32'h400, 32'h0, 32'h55AA55AA, 1'b0, 0, 1'b1);
        chk("hold_rd",  res_rd, 32'h55AA55AA);
        chk("hold_ill", 32'({res_ill, res_mis}), 32'h0);
        chk("hold_lat", 32'(res_lat), 32'd2);

        // Reset during a stalled AMO write
        i_start = 1'b1; i_funct5 = 5'b00000; i_addr = 32'h500; i_rs2 = 32'h1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        chk("ra_rdreq", 32'({o_mem_req, o_mem_we}), 32'h2);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hA;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        chk("ra_wrreq", 32'({o_mem_req, o_mem_we}), 32'h3);
        repeat (3) @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        chk("ra_req_drop", 32'(o_mem_req), 32'h0);
        chk("ra_busy",     32'(o_busy), 32'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        begin
            int spur;
            spur = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge i_clk); #1;
                if (o_done || o_res_wr || o_mem_req || o_busy) spur++;
            end
            chk("ra_no_done", 32'(spur), 32'h0);
        end
        do_op(5'b00000, 32'h500, 32'h3, 32'h7, 1'b0, 0, 1'b0);
        chk("ra_next_lat",   32'(res_lat), 32'd3);
        chk("ra_next_wdata", res_wdata, 32'hA);
        chk("ra_next_rd",    res_rd, 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
